// File: rtl/alu_cond_writeback_if.sv
// ALU-to-writeback channel bundle: an accept side carrying ALU result, flags
// and condition information, and a drain side carrying buffered results.
interface alu_cond_writeback_if #(
  parameter int WIDTH = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic [3:0]       cond;
  logic [1:0]       flag_write;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_exec;
  logic [3:0]       out_flags;

  // Upstream producer / downstream consumer seen from outside the block
  modport master (
    output in_valid, alu_result, alu_flags, cond, flag_write, out_ready,
    input  in_ready, out_valid, out_data, out_exec, out_flags
  );

  // The writeback block itself
  modport slave (
    input  in_valid, alu_result, alu_flags, cond, flag_write, out_ready,
    output in_ready, out_valid, out_data, out_exec, out_flags
  );
endinterface

// File: rtl/alu_cond_writeback.sv
// Conditional-execution writeback stage: evaluates an ARM-style condition
// against the architectural NZCV register, applies masked flag updates and
// queues every operation (passed or failed) in a small in-order FIFO.
module alu_cond_writeback #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  alu_cond_writeback_if.slave bus,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] drop_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = WIDTH + 5;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DROP_ONE = 1;

  logic [3:0]       flags_q, flags_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] entry_d;
  logic [ENT_W-1:0] head;
  logic             push, pop, pass;

  // Condition code against the pre-update flag register {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = !z;
      4'b0010: cond_eval = cf;
      4'b0011: cond_eval = !cf;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = !n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = !v;
      4'b1000: cond_eval = cf && !z;
      4'b1001: cond_eval = !cf || z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = !z && (n == v);
      4'b1101: cond_eval = z || (n != v);
      default: cond_eval = 1'b1;
    endcase
  endfunction

  // Counter increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    sat_inc = (&x) ? x : x + DROP_ONE;
  endfunction

  assign bus.in_ready  = (count_q < CNT_FULL);
  assign bus.out_valid = (count_q != '0);
  assign head          = mem_q[rd_ptr_q];
  assign bus.out_data  = bus.out_valid ? head[ENT_W-1:5] : '0;
  assign bus.out_exec  = bus.out_valid ? head[4] : 1'b0;
  assign bus.out_flags = bus.out_valid ? head[3:0] : 4'b0000;
  assign flags         = flags_q;
  assign drop_count    = drop_q;

  // Next-state: accept/pop decode, masked flag update, pointers and counters
  always_comb begin
    push     = bus.in_valid && bus.in_ready;
    pop      = bus.out_valid && bus.out_ready;
    pass     = cond_eval(bus.cond, flags_q);
    flags_d  = flags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) begin
      if (pass) begin
        if (bus.flag_write[1]) flags_d[3:2] = bus.alu_flags[3:2];
        if (bus.flag_write[0]) flags_d[1:0] = bus.alu_flags[1:0];
      end else begin
        drop_d = sat_inc(drop_q);
      end
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    entry_d = {bus.alu_result, pass, flags_d};
  end

  // Control and architectural state, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q  <= 4'b0000;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      flags_q  <= flags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; contents are masked at the output while empty, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end
endmodule

// File: tb/tb_alu_cond_writeback.sv
// Randomized and directed bench for alu_cond_writeback against a queue model.
module tb_alu_cond_writeback;
  localparam int WIDTH = 5;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] flags;
  logic [CNT_W-1:0] drop_count;

  always #5 clk = ~clk;

  alu_cond_writeback_if #(.WIDTH(WIDTH)) bus ();

  alu_cond_writeback #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .flags(flags),
    .drop_count(drop_count)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             exec;
    logic [3:0]       fl;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] mflags;
  int         mdrop;
  int         n_chk = 0;
  int         n_bad = 0;
  logic       last_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Condition = base predicate selected by cond[3:1], inverted by cond[0]
  function automatic logic mdl_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".flags"}, 32'(flags), 32'(mflags));
    chk({tag, ".drop"}, 32'(drop_count), 32'(mdrop));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    if (mq.size() != 0) begin
      chk({tag, ".out_data"}, 32'(bus.out_data), 32'(mq[0].data));
      chk({tag, ".out_exec"}, 32'(bus.out_exec), 32'(mq[0].exec));
      chk({tag, ".out_flags"}, 32'(bus.out_flags), 32'(mq[0].fl));
    end else begin
      chk({tag, ".out_data0"}, 32'(bus.out_data), 32'd0);
      chk({tag, ".out_exec0"}, 32'(bus.out_exec), 32'd0);
      chk({tag, ".out_flags0"}, 32'(bus.out_flags), 32'd0);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, check at next negedge
  task automatic cycle(input string tag, input logic v, input logic [WIDTH-1:0] r,
                       input logic [3:0] f, input logic [3:0] c,
                       input logic [1:0] fw, input logic ordy);
    logic acc, pp, ok;
    logic [3:0] nf;
    bus.in_valid   = v;
    bus.alu_result = r;
    bus.alu_flags  = f;
    bus.cond       = c;
    bus.flag_write = fw;
    bus.out_ready  = ordy;
    acc = v && (mq.size() < DEPTH);
    pp  = ordy && (mq.size() != 0);
    ok  = mdl_pass(c, mflags);
    @(posedge clk);
    if (pp) void'(mq.pop_front());
    if (acc) begin
      nf = mflags;
      if (ok) begin
        if (fw[1]) nf[3:2] = f[3:2];
        if (fw[0]) nf[1:0] = f[1:0];
      end else if (mdrop < DROP_MAX) begin
        mdrop++;
      end
      mflags = nf;
      mq.push_back('{data: r, exec: ok, fl: nf});
    end
    last_acc = acc;
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    mflags = 4'b0000;
    mdrop  = 0;
  endtask

  logic             rv, ro;
  logic [WIDTH-1:0] rr;
  logic [3:0]       rf, rc;
  logic [1:0]       rw;

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.alu_result = '0; bus.alu_flags = '0;
    bus.cond = '0; bus.flag_write = '0; bus.out_ready = 1'b0;
    model_reset();
    last_acc = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("rst");
    chk("rst.in_ready_hi", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // AL with full flag write, then EQ against the new Z
    cycle("al", 1'b1, 5'd0, 4'b0100, 4'b1110, 2'b11, 1'b0);
    chk("al.flags_c", 32'(flags), 32'h4);
    chk("al.exec_c", 32'(bus.out_exec), 32'd1);
    chk("al.oflags_c", 32'(bus.out_flags), 32'h4);
    cycle("eq", 1'b1, 5'd3, 4'b1111, 4'b0000, 2'b00, 1'b0);
    cycle("drain1", 1'b0, 5'd0, 4'b0, 4'b0, 2'b0, 1'b1);
    chk("eq.exec_c", 32'(bus.out_exec), 32'd1);
    chk("eq.data_c", 32'(bus.out_data), 32'd3);
    cycle("drain2", 1'b0, 5'd0, 4'b0, 4'b0, 2'b0, 1'b1);

    // NE fails with Z set
    cycle("ne", 1'b1, 5'd7, 4'b1000, 4'b0001, 2'b11, 1'b0);
    chk("ne.exec_c", 32'(bus.out_exec), 32'd0);
    chk("ne.flags_c", 32'(flags), 32'h4);
    chk("ne.drop_c", 32'(drop_count), 32'd1);
    cycle("drain3", 1'b0, 5'd0, 4'b0, 4'b0, 2'b0, 1'b1);

    // Backpressure: fill, refused push, single pop, then accept
    cycle("full1", 1'b1, 5'd1, 4'b0, 4'b1110, 2'b00, 1'b0);
    cycle("full2", 1'b1, 5'd2, 4'b0, 4'b1110, 2'b00, 1'b0);
    chk("full.in_ready_c", 32'(bus.in_ready), 32'd0);
    cycle("refuse", 1'b1, 5'd3, 4'b0, 4'b1110, 2'b00, 1'b0);
    chk("refuse.head_c", 32'(bus.out_data), 32'd1);
    cycle("popfull", 1'b1, 5'd3, 4'b0, 4'b1110, 2'b00, 1'b1);
    chk("popfull.in_ready_c", 32'(bus.in_ready), 32'd1);
    chk("popfull.head_c", 32'(bus.out_data), 32'd2);
    cycle("take3", 1'b1, 5'd3, 4'b0, 4'b1110, 2'b00, 1'b0);
    cycle("pop2", 1'b0, 5'd0, 4'b0, 4'b0, 2'b0, 1'b1);
    chk("pop2.head_c", 32'(bus.out_data), 32'd3);
    cycle("pop3", 1'b0, 5'd0, 4'b0, 4'b0, 2'b0, 1'b1);
    cycle("empty_pop", 1'b0, 5'd0, 4'b0, 4'b0, 2'b0, 1'b1);

    // Simultaneous push and pop at count 1
    cycle("one", 1'b1, 5'd9, 4'b0, 4'b1110, 2'b00, 1'b0);
    cycle("pushpop", 1'b1, 5'd10, 4'b0, 4'b1110, 2'b00, 1'b1);
    chk("pushpop.valid_c", 32'(bus.in_ready), 32'd1);
    chk("pushpop.head_c", 32'(bus.out_data), 32'd10);

    // Signed conditions (count held at 1 so head is always the latest push)
    cycle("set1001", 1'b1, 5'd11, 4'b1001, 4'b1110, 2'b11, 1'b1);
    cycle("ge_p", 1'b1, 5'd12, 4'b0000, 4'b1010, 2'b00, 1'b1);
    chk("ge_p.exec_c", 32'(bus.out_exec), 32'd1);
    cycle("lt_f", 1'b1, 5'd13, 4'b0000, 4'b1011, 2'b00, 1'b1);
    chk("lt_f.exec_c", 32'(bus.out_exec), 32'd0);
    cycle("set1000", 1'b1, 5'd14, 4'b1000, 4'b1110, 2'b11, 1'b1);
    cycle("ge_f", 1'b1, 5'd15, 4'b0000, 4'b1010, 2'b00, 1'b1);
    chk("ge_f.exec_c", 32'(bus.out_exec), 32'd0);
    cycle("lt_p", 1'b1, 5'd16, 4'b0000, 4'b1011, 2'b00, 1'b1);
    chk("lt_p.exec_c", 32'(bus.out_exec), 32'd1);
    cycle("gt_f", 1'b1, 5'd17, 4'b0000, 4'b1100, 2'b00, 1'b1);
    chk("gt_f.exec_c", 32'(bus.out_exec), 32'd0);

    // Asynchronous reset mid-cycle with an entry buffered
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst.flags", 32'(flags), 32'd0);
    chk("arst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst.drop", 32'(drop_count), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("arst_rel");

    // Random traffic; held inputs until accepted, long enough to saturate drops
    rv = 1'b0; rr = '0; rf = '0; rc = '0; rw = '0;
    last_acc = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      if (!rv || last_acc) begin
        rv = ($urandom_range(0, 9) < 7);
        rr = WIDTH'($urandom);
        rf = 4'($urandom);
        rc = 4'($urandom);
        rw = 2'($urandom);
      end
      ro = ($urandom_range(0, 9) < 6);
      cycle("rnd", rv, rr, rf, rc, rw, ro);
    end
    chk("rnd.drop_sat", 32'(drop_count), 32'(DROP_MAX));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_cond_writeback.md
Name: alu_cond_writeback

Overview:
- Consumer end of the ALU result/flag interface: accepts each ALU operation's Result and NZCV ALUFlags, and evaluates a 4-bit ARM-style condition against the architectural flag register.
- Updates flags under a per-group write mask.
- Queues results in a small FIFO for a downstream register-file or display writer, behind a valid/ready handshake.
- Sits between the ALU/shifter datapath and writeback on the Basys lab design.

Parameters:
- WIDTH, 5, data width of ALU result.
- DEPTH, 2, output buffer entries (power of two, >= 2).
- CNT_W, 8, width of the dropped-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU operation presented.
- in_ready  output  1  block can accept an operation.
- alu_result  input  WIDTH  ALU Result.
- alu_flags  input  4  ALUFlags {N,Z,C,V}.
- cond  input  4  condition code of the operation.
- flag_write  input  2  bit1 = write N,Z; bit0 = write C,V.
- out_valid  output  1  head entry available.
- out_ready  input  1  downstream accepts head entry.
- out_data  output  WIDTH  head entry result.
- out_exec  output  1  head entry condition passed (write enable for downstream).
- out_flags  output  4  flag register value after the head entry's update.
- flags  output  4  current architectural flags {N,Z,C,V}.
- drop_count  output  CNT_W  saturating count of condition-failed operations.

Behaviour:
- Reset: while reset is high, the block is held in reset asynchronously.
  - flags=0000, FIFO count/pointers=0, drop_count=0.
  - out_valid=0, out_data=0, out_exec=0, out_flags=0.
  - in_ready=1 once reset deasserts.
  - Reset mid-stream discards all buffered entries.
- Accept: occurs on a clk edge with in_valid && in_ready.
  - in_ready = (count < DEPTH), combinational from registered count. There is no bypass when full.
- Condition evaluation: combinational, from the flags register value before the accepting edge.
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: 1 (treated as AL).
- Flag update on an accepting edge when the condition passes:
  - flags[3:2] <= alu_flags[3:2] if flag_write[1].
  - flags[1:0] <= alu_flags[1:0] if flag_write[0].
  - A failed condition leaves flags unchanged.
  - A back-to-back next operation sees the updated flags: one-cycle flag latency, no hazard stall.
- FIFO push on accept:
  - Entry = {alu_result, pass, flags value after this edge's update}.
  - Failed operations are still pushed, with exec=0, to preserve ordering.
  - drop_count increments on each accepted failed operation and saturates at 2^CNT_W-1.
- Output:
  - out_valid = (count != 0).
  - out_data, out_exec, out_flags show the head entry, or 0 when empty.
  - Pop on a clk edge with out_valid && out_ready.
  - Push-to-out_valid latency: 1 cycle (visible the cycle after the accepting edge).
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, FIFO order preserved.
- Full: in_ready=0. A pop while full frees a slot, and in_ready rises the cycle after that pop edge.
- Empty with out_ready=1: nothing happens.
- Pointers wrap modulo DEPTH.
- Input stability: alu_result, alu_flags, cond and flag_write need be stable only while in_valid is high. Upstream holds them until accepted.

Test Plan:
1. Reset check: assert reset asynchronously mid-cycle -> immediately flags=0000, out_valid=0, drop_count=0. After release, in_ready=1.
2. AL then EQ:
   - Push result=5'd0, alu_flags=0100, cond=1110, flag_write=11 -> next cycle flags=0100, out_valid=1, out_data=0, out_exec=1, out_flags=0100.
   - Then push result=5'd3, cond=0000, flag_write=00 -> entry exec=1, flags stay 0100.
3. Failed condition: with flags=0100, push result=5'd7, alu_flags=1000, cond=0001 NE, flag_write=11 -> out_exec=0, flags remain 0100, drop_count=1.
4. Full/backpressure:
   - With out_ready=0, push 2 entries (data 1, 2) -> in_ready=0. A third in_valid (data 3) is not accepted.
   - Pulse out_ready one cycle -> data 1 popped, in_ready=1 next cycle, data 3 accepted, order 2 then 3.
5. Simultaneous push/pop: at count=1, in_valid=1 and out_ready=1 on the same edge -> count stays 1, out_data advances to the newly pushed value.
6. Signed conditions: set flags=1001 via AL, flag_write=11 -> GE (1010) passes and LT (1011) fails. Then set flags=1000 -> GE fails, LT passes, GT fails.
